game_logic_multi: RTL and testbench



---
 rtl/game_logic_multi_pkg.sv | 33 +++
 rtl/game_logic_multi_collision_latch.sv | 53 +++++
 rtl/game_logic_multi.sv | 248 ++++++++++++++++++++++++
 tb/tb_game_logic_multi.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_logic_multi_pkg.sv
// Shared definitions for the multi-life ball/paddle controller.
//   state_e    : game state encoding, also driven out on game_state
//   force_sign : returns +|v| or -|v|, used to steer the ball away from a wall
//   seg_to_vx  : maps the paddle segment under the ball to a horizontal velocity
package game_logic_multi_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StServe    = 3'd1,
    StPlaying  = 3'd2,
    StLost     = 3'd3,
    StGameOver = 3'd4
  } state_e;

  // Forcing the sign, instead of negating it, stops a contact that lasts
  // several frames from flipping the ball back into the wall.
  function automatic int force_sign(input int v, input logic positive);
    int mag;
    mag = (v < 0) ? -v : v;
    return positive ? mag : -mag;
  endfunction

  // The left half of the paddle sends the ball left and the right half sends
  // it right. The outer segments give the steepest angles, and no segment
  // gives vx = 0.
  function automatic int seg_to_vx(input int seg, input int num_seg);
    int half;
    half = num_seg / 2;
    if (seg < half) return -(half - seg);
    return seg - half + 1;
  endfunction

endpackage

// File: rtl/game_logic_multi_collision_latch.sv
// Per-frame collision latch bank.
//   Inputs : clk, rst, frame_pulse, collision qualifier, block/paddle hit,
//            paddle_segment, ball edge contacts (top/left/bottom/right)
//   Outputs: lat_* flags that stay set until the next frame_pulse, and
//            lat_segment, the last segment seen under a paddle contact
// The consumer samples the flags on the frame_pulse cycle, which is the same
// cycle on which they are cleared.
module game_logic_multi_collision_latch #(
  parameter int unsigned SEG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_pulse,
  input  logic             collision,
  input  logic             block_collision,
  input  logic             paddle_collision,
  input  logic [SEG_W-1:0] paddle_segment,
  input  logic             top_col,
  input  logic             left_col,
  input  logic             bottom_col,
  input  logic             right_col,
  output logic             lat_block,
  output logic             lat_paddle,
  output logic             lat_top,
  output logic             lat_left,
  output logic             lat_bottom,
  output logic             lat_right,
  output logic [SEG_W-1:0] lat_segment
);

  // {block, paddle, top, left, bottom, right}
  logic [5:0]       flags_q;
  logic [SEG_W-1:0] seg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
      seg_q   <= '0;
    end else begin
      if (frame_pulse) begin
        flags_q <= '0;
      end else if (collision) begin
        flags_q <= flags_q | {block_collision, paddle_collision, top_col,
                              left_col, bottom_col, right_col};
      end
      if (paddle_collision) seg_q <= paddle_segment;
    end
  end

  assign {lat_block, lat_paddle, lat_top, lat_left, lat_bottom, lat_right} = flags_q;
  assign lat_segment = seg_q;

endmodule

// File: rtl/game_logic_multi.sv
// Ball/paddle game controller with lives, serve phase, post-miss pause and
// speed levels.
//   Inputs : clk, rst (async, active high), frame_pulse, buttons,
//            collision qualifier with block/paddle/edge contacts and
//            paddle_segment, cmd_stop_game
//   Outputs: ball_x/ball_y (integer pixels), paddle_x, game_state, lives,
//            speed_level, ball_out_of_bounds, latched_ball_block_collision
// Apart from the collision latches, the state changes only on frame_pulse.
module game_logic_multi
  import game_logic_multi_pkg::*;
#(
  parameter int unsigned SCREEN_W       = 640,
  parameter int unsigned OOB_Y          = 488,
  parameter int unsigned BORDER_WIDTH   = 8,
  parameter int unsigned PADDLE_WIDTH   = 64,
  parameter int unsigned PADDLE_Y       = 452,
  parameter int unsigned BALL_SIZE      = 4,
  parameter int unsigned PADDLE_SPEED   = 2,
  parameter int unsigned FRAC_BITS      = 1,
  parameter int unsigned VEL_W          = 5,
  parameter int unsigned BASE_VY        = 2,
  parameter int unsigned NUM_SEG        = 6,
  parameter int unsigned LIVES          = 3,
  parameter int unsigned HITS_PER_LEVEL = 8,
  parameter int unsigned MAX_LEVEL      = 3,
  parameter int unsigned PAUSE_FRAMES   = 60,
  localparam int unsigned SEG_W         = $clog2(NUM_SEG),
  localparam int unsigned LIVES_W       = $clog2(LIVES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_pulse,
  input  logic               btn_action,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               collision,
  input  logic               block_collision,
  input  logic               paddle_collision,
  input  logic [SEG_W-1:0]   paddle_segment,
  input  logic               ball_top_col,
  input  logic               ball_left_col,
  input  logic               ball_bottom_col,
  input  logic               ball_right_col,
  input  logic               cmd_stop_game,
  output logic [9:0]         ball_x,
  output logic [8:0]         ball_y,
  output logic [9:0]         paddle_x,
  output logic [2:0]         game_state,
  output logic [LIVES_W-1:0] lives,
  output logic [1:0]         speed_level,
  output logic               ball_out_of_bounds,
  output logic               latched_ball_block_collision
);

  localparam int unsigned X_W     = 10 + FRAC_BITS;
  localparam int unsigned Y_W     = 9 + FRAC_BITS;
  localparam int unsigned HIT_W   = $clog2(HITS_PER_LEVEL + 1);
  localparam int unsigned PAUSE_W = $clog2(PAUSE_FRAMES + 1);

  localparam logic [9:0] PADDLE_MIN  = 10'(BORDER_WIDTH);
  localparam logic [9:0] PADDLE_MAX  = 10'(SCREEN_W - BORDER_WIDTH - PADDLE_WIDTH);
  localparam logic [9:0] PADDLE_STEP = 10'(PADDLE_SPEED);
  localparam logic [9:0] LEFT_LIMIT  = PADDLE_MIN + PADDLE_STEP;
  localparam logic [9:0] RIGHT_LIMIT = PADDLE_MAX - PADDLE_STEP;
  localparam logic [9:0] PADDLE_HOME = 10'(SCREEN_W / 2 - PADDLE_WIDTH / 2);
  localparam logic [9:0] BALL_OFS    = 10'(PADDLE_WIDTH / 2 - BALL_SIZE / 2);

  localparam logic [X_W-1:0]     HOME_BX    = X_W'((PADDLE_HOME + BALL_OFS) << FRAC_BITS);
  localparam logic [Y_W-1:0]     SERVE_BY   = Y_W'((PADDLE_Y - BALL_SIZE) << FRAC_BITS);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [HIT_W-1:0]   HIT_LAST   = HIT_W'(HITS_PER_LEVEL - 1);
  localparam logic [PAUSE_W-1:0] PAUSE_INIT = PAUSE_W'(PAUSE_FRAMES - 1);
  localparam logic [1:0]         LEVEL_MAX  = 2'(MAX_LEVEL);

  state_e                   state_q;
  logic [LIVES_W-1:0]       lives_q;
  logic [1:0]               level_q;
  logic [HIT_W-1:0]         hits_q;
  logic [PAUSE_W-1:0]       pause_q;
  logic                     act_prev_q;
  logic [9:0]               paddle_q;
  logic [X_W-1:0]           bx_q;
  logic [Y_W-1:0]           by_q;
  logic signed [VEL_W-1:0]  vx_q;
  logic signed [VEL_W-1:0]  vy_q;

  logic                     lat_block, lat_paddle, lat_top, lat_left, lat_bottom, lat_right;
  logic [SEG_W-1:0]         lat_seg;

  logic                     action_edge;
  logic [9:0]               paddle_nxt;
  logic [X_W-1:0]           serve_bx;
  logic signed [VEL_W-1:0]  serve_vy;
  logic signed [VEL_W-1:0]  vx_new;
  logic signed [VEL_W-1:0]  vy_new;
  logic [X_W-1:0]           bx_nxt;
  logic [Y_W-1:0]           by_nxt;
  int                       vmag;

  game_logic_multi_collision_latch #(
    .SEG_W (SEG_W)
  ) u_latch (
    .clk              (clk),
    .rst              (rst),
    .frame_pulse      (frame_pulse),
    .collision        (collision),
    .block_collision  (block_collision),
    .paddle_collision (paddle_collision),
    .paddle_segment   (paddle_segment),
    .top_col          (ball_top_col),
    .left_col         (ball_left_col),
    .bottom_col       (ball_bottom_col),
    .right_col        (ball_right_col),
    .lat_block        (lat_block),
    .lat_paddle       (lat_paddle),
    .lat_top          (lat_top),
    .lat_left         (lat_left),
    .lat_bottom       (lat_bottom),
    .lat_right        (lat_right),
    .lat_segment      (lat_seg)
  );

  assign action_edge = btn_action & ~act_prev_q;

  // Paddle step, clamped so that it stops exactly on either wall.
  always_comb begin
    paddle_nxt = paddle_q;
    if (btn_left) begin
      paddle_nxt = (paddle_q < LEFT_LIMIT) ? PADDLE_MIN : paddle_q - PADDLE_STEP;
    end else if (btn_right) begin
      paddle_nxt = (paddle_q > RIGHT_LIMIT) ? PADDLE_MAX : paddle_q + PADDLE_STEP;
    end
  end

  assign serve_bx = X_W'(paddle_nxt + BALL_OFS) << FRAC_BITS;

  // Bounce resolution. A paddle hit sets both components, which also makes it
  // the point where a new speed level takes effect. Wall hits only force signs.
  always_comb begin
    vmag     = int'(BASE_VY) + int'(level_q);
    serve_vy = VEL_W'(-vmag);
    vx_new   = vx_q;
    vy_new   = vy_q;
    if (lat_paddle && lat_bottom) begin
      vx_new = VEL_W'(seg_to_vx(int'(lat_seg), int'(NUM_SEG)));
      vy_new = VEL_W'(-vmag);
    end else begin
      if (lat_top ^ lat_bottom) vy_new = VEL_W'(force_sign(int'(vy_q), lat_top));
      if (lat_left ^ lat_right) vx_new = VEL_W'(force_sign(int'(vx_q), lat_left));
    end
  end

  assign bx_nxt = bx_q + {{(X_W - VEL_W){vx_new[VEL_W-1]}}, vx_new};
  assign by_nxt = by_q + {{(Y_W - VEL_W){vy_new[VEL_W-1]}}, vy_new};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      lives_q    <= LIVES_INIT;
      level_q    <= '0;
      hits_q     <= '0;
      pause_q    <= '0;
      act_prev_q <= 1'b1;
      paddle_q   <= PADDLE_HOME;
      bx_q       <= HOME_BX;
      by_q       <= SERVE_BY;
      vx_q       <= '0;
      vy_q       <= '0;
    end else if (frame_pulse) begin
      act_prev_q <= btn_action;
      if (cmd_stop_game) begin
        state_q <= StIdle;
        vx_q    <= '0;
        vy_q    <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (action_edge) begin
              state_q <= StServe;
              lives_q <= LIVES_INIT;
              level_q <= '0;
              hits_q  <= '0;
            end
          end
          StServe: begin
            paddle_q <= paddle_nxt;
            bx_q     <= serve_bx;
            by_q     <= SERVE_BY;
            if (action_edge) begin
              state_q <= StPlaying;
              vx_q    <= VEL_W'(1);
              vy_q    <= serve_vy;
            end
          end
          StPlaying: begin
            paddle_q <= paddle_nxt;
            if (lat_block) begin
              if (hits_q == HIT_LAST) begin
                hits_q <= '0;
                if (level_q != LEVEL_MAX) level_q <= level_q + 2'd1;
              end else begin
                hits_q <= hits_q + HIT_W'(1);
              end
            end
            if (ball_out_of_bounds) begin
              vx_q <= '0;
              vy_q <= '0;
              if (lives_q == LIVES_W'(1)) begin
                state_q <= StGameOver;
                lives_q <= '0;
              end else begin
                state_q  <= StLost;
                lives_q  <= lives_q - LIVES_W'(1);
                pause_q  <= PAUSE_INIT;
                paddle_q <= PADDLE_HOME;
                bx_q     <= HOME_BX;
                by_q     <= SERVE_BY;
              end
            end else begin
              vx_q <= vx_new;
              vy_q <= vy_new;
              bx_q <= bx_nxt;
              by_q <= by_nxt;
            end
          end
          StLost: begin
            if (pause_q == '0) state_q <= StServe;
            else pause_q <= pause_q - PAUSE_W'(1);
          end
          StGameOver: begin
            if (action_edge) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign ball_x                       = 10'(bx_q >> FRAC_BITS);
  assign ball_y                       = 9'(by_q >> FRAC_BITS);
  assign paddle_x                     = paddle_q;
  assign game_state                   = state_q;
  assign lives                        = lives_q;
  assign speed_level                  = level_q;
  assign ball_out_of_bounds           = (ball_y >= 9'(OOB_Y));
  assign latched_ball_block_collision = lat_block;

endmodule

// File: tb/tb_game_logic_multi.sv
module tb_game_logic_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_pulse = 1'b0;
  logic       btn_action = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       collision = 1'b0, block_collision = 1'b0, paddle_collision = 1'b0;
  logic [2:0] paddle_segment = 3'd0;
  logic       ball_top_col = 1'b0, ball_left_col = 1'b0;
  logic       ball_bottom_col = 1'b0, ball_right_col = 1'b0;
  logic       cmd_stop_game = 1'b0;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [9:0] paddle_x;
  logic [2:0] game_state;
  logic [1:0] lives;
  logic [1:0] speed_level;
  logic       ball_out_of_bounds;
  logic       latched_ball_block_collision;

  int vectors = 0;
  int miscompares = 0;

  game_logic_multi dut (
    .clk                          (clk),
    .rst                          (rst),
    .frame_pulse                  (frame_pulse),
    .btn_action                   (btn_action),
    .btn_left                     (btn_left),
    .btn_right                    (btn_right),
    .collision                    (collision),
    .block_collision              (block_collision),
    .paddle_collision             (paddle_collision),
    .paddle_segment               (paddle_segment),
    .ball_top_col                 (ball_top_col),
    .ball_left_col                (ball_left_col),
    .ball_bottom_col              (ball_bottom_col),
    .ball_right_col               (ball_right_col),
    .cmd_stop_game                (cmd_stop_game),
    .ball_x                       (ball_x),
    .ball_y                       (ball_y),
    .paddle_x                     (paddle_x),
    .game_state                   (game_state),
    .lives                        (lives),
    .speed_level                  (speed_level),
    .ball_out_of_bounds           (ball_out_of_bounds),
    .latched_ball_block_collision (latched_ball_block_collision)
  );

  always #5 clk = ~clk;

  task automatic frame();
    @(negedge clk); frame_pulse = 1'b1;
    @(negedge clk); frame_pulse = 1'b0;
  endtask

  task automatic collide(input logic blk, input logic pad, input logic [2:0] seg,
                         input logic t, input logic l, input logic b, input logic r);
    @(negedge clk);
    collision = 1'b1; block_collision = blk; paddle_collision = pad; paddle_segment = seg;
    ball_top_col = t; ball_left_col = l; ball_bottom_col = b; ball_right_col = r;
    @(negedge clk);
    collision = 1'b0; block_collision = 1'b0; paddle_collision = 1'b0;
    ball_top_col = 1'b0; ball_left_col = 1'b0; ball_bottom_col = 1'b0; ball_right_col = 1'b0;
  endtask

  // Action press from SERVE: release frame, then press frame.
  task automatic launch();
    btn_action = 1'b0; frame();
    btn_action = 1'b1; frame();
    btn_action = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_action = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    vectors++; if (game_state !== 3'd0) begin miscompares++;
      $display("FAIL reset_state: got %0d want 0", game_state); end
    vectors++; if (lives !== 2'd3) begin miscompares++;
      $display("FAIL reset_lives: got %0d want 3", lives); end
    vectors++; if (paddle_x !== 10'd288) begin miscompares++;
      $display("FAIL reset_paddle: got %0d want 288", paddle_x); end
    vectors++; if (ball_x !== 10'd318 || ball_y !== 9'd448) begin miscompares++;
      $display("FAIL reset_ball: got %0d,%0d want 318,448", ball_x, ball_y); end
    vectors++; if (speed_level !== 2'd0 || ball_out_of_bounds !== 1'b0 ||
                   latched_ball_block_collision !== 1'b0) begin miscompares++;
      $display("FAIL reset_misc: got lvl %0d oob %0d blk %0d want 0 0 0",
               speed_level, ball_out_of_bounds, latched_ball_block_collision); end
    repeat (3) frame();
    vectors++; if (game_state !== 3'd0) begin miscompares++;
      $display("FAIL held_action_start: got %0d want 0", game_state); end
    btn_action = 1'b0; frame();
    btn_action = 1'b1; frame();
    btn_action = 1'b0;
    vectors++; if (game_state !== 3'd1 || lives !== 2'd3) begin miscompares++;
      $display("FAIL idle_to_serve: got st %0d lives %0d want 1 3", game_state, lives); end
  endtask

  task automatic test_serve();
    int vx_obs, vy_obs;
    launch();
    vx_obs = int'(dut.vx_q); vy_obs = int'(dut.vy_q);
    vectors++; if (game_state !== 3'd2) begin miscompares++;
      $display("FAIL serve_to_play: got %0d want 2", game_state); end
    vectors++; if (vx_obs != 1 || vy_obs != -2) begin miscompares++;
      $display("FAIL serve_vel: got %0d,%0d want 1,-2", vx_obs, vy_obs); end
    vectors++; if (ball_x !== 10'd318 || ball_y !== 9'd448) begin miscompares++;
      $display("FAIL serve_pos: got %0d,%0d want 318,448", ball_x, ball_y); end
    frame(); frame();
    vectors++; if (ball_x !== 10'd319 || ball_y !== 9'd446) begin miscompares++;
      $display("FAIL play_move: got %0d,%0d want 319,446", ball_x, ball_y); end
  endtask

  task automatic test_bounce();
    int vx_obs, vy_obs;
    collide(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0); frame();
    vx_obs = int'(dut.vx_q); vy_obs = int'(dut.vy_q);
    vectors++; if (vx_obs != -3 || vy_obs != -2) begin miscompares++;
      $display("FAIL seg0_vel: got %0d,%0d want -3,-2", vx_obs, vy_obs); end
    vectors++; if (ball_x !== 10'd317 || ball_y !== 9'd445) begin miscompares++;
      $display("FAIL seg0_pos: got %0d,%0d want 317,445", ball_x, ball_y); end
    collide(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0); frame();
    vx_obs = int'(dut.vx_q);
    vectors++; if (vx_obs != 3 || ball_x !== 10'd319) begin miscompares++;
      $display("FAIL seg5: got vx %0d x %0d want 3 319", vx_obs, ball_x); end
    collide(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0); frame();
    vx_obs = int'(dut.vx_q);
    vectors++; if (vx_obs != -1 || ball_y !== 9'd443) begin miscompares++;
      $display("FAIL seg2: got vx %0d y %0d want -1 443", vx_obs, ball_y); end
    collide(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0); frame();
    vx_obs = int'(dut.vx_q); vy_obs = int'(dut.vy_q);
    vectors++; if (vx_obs != 1 || vy_obs != 2 || ball_y !== 9'd444) begin miscompares++;
      $display("FAIL top_left: got %0d,%0d y %0d want 1,2 444", vx_obs, vy_obs, ball_y); end
    collide(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0); frame();
    vy_obs = int'(dut.vy_q);
    vectors++; if (vy_obs != 2 || ball_y !== 9'd445) begin miscompares++;
      $display("FAIL top_sticky: got vy %0d y %0d want 2 445", vy_obs, ball_y); end
    collide(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1); frame();
    vx_obs = int'(dut.vx_q); vy_obs = int'(dut.vy_q);
    vectors++; if (vx_obs != -1 || vy_obs != -2 || ball_x !== 10'd319 || ball_y !== 9'd444)
    begin miscompares++;
      $display("FAIL bottom_right: got %0d,%0d pos %0d,%0d want -1,-2 319,444",
               vx_obs, vy_obs, ball_x, ball_y); end
  endtask

  task automatic test_speed();
    int vx_obs, vy_obs;
    for (int i = 0; i < 8; i++) begin
      collide(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 0) begin
        vectors++; if (latched_ball_block_collision !== 1'b1) begin miscompares++;
          $display("FAIL block_latch_set: got %0d want 1", latched_ball_block_collision); end
      end
      frame();
      if (i == 0) begin
        vectors++; if (latched_ball_block_collision !== 1'b0) begin miscompares++;
          $display("FAIL block_latch_clr: got %0d want 0", latched_ball_block_collision); end
      end
      if (i == 6) begin
        vectors++; if (speed_level !== 2'd0) begin miscompares++;
          $display("FAIL level_after7: got %0d want 0", speed_level); end
      end
    end
    vectors++; if (speed_level !== 2'd1) begin miscompares++;
      $display("FAIL level_after8: got %0d want 1", speed_level); end
    collide(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0); frame();
    vx_obs = int'(dut.vx_q); vy_obs = int'(dut.vy_q);
    vectors++; if (vx_obs != 1 || vy_obs != -3) begin miscompares++;
      $display("FAIL level1_bounce: got %0d,%0d want 1,-3", vx_obs, vy_obs); end
    for (int i = 0; i < 24; i++) begin
      collide(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); frame();
      if (i == 7) begin
        vectors++; if (speed_level !== 2'd2) begin miscompares++;
          $display("FAIL level_after16: got %0d want 2", speed_level); end
      end
    end
    vectors++; if (speed_level !== 2'd3) begin miscompares++;
      $display("FAIL level_sat: got %0d want 3", speed_level); end
    vectors++; if (ball_x !== 10'd327 || ball_y !== 9'd398) begin miscompares++;
      $display("FAIL speed_pos: got %0d,%0d want 327,398", ball_x, ball_y); end
    collide(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0); frame();
    vx_obs = int'(dut.vx_q); vy_obs = int'(dut.vy_q);
    vectors++; if (vx_obs != 2 || vy_obs != -5) begin miscompares++;
      $display("FAIL level3_bounce: got %0d,%0d want 2,-5", vx_obs, vy_obs); end
  endtask

  task automatic test_stop();
    collide(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cmd_stop_game = 1'b1; frame(); cmd_stop_game = 1'b0;
    vectors++; if (game_state !== 3'd0 || paddle_x !== 10'd288) begin miscompares++;
      $display("FAIL stop: got st %0d paddle %0d want 0 288", game_state, paddle_x); end
  endtask

  task automatic test_lives();
    int n;
    btn_action = 1'b0; frame();
    btn_action = 1'b1; frame();
    btn_action = 1'b0;
    vectors++; if (game_state !== 3'd1 || lives !== 2'd3 || speed_level !== 2'd0) begin
      miscompares++;
      $display("FAIL restart: got st %0d lives %0d lvl %0d want 1 3 0",
               game_state, lives, speed_level); end
    for (int r = 0; r < 3; r++) begin
      launch();
      collide(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0); frame();
      n = 0;
      while (ball_out_of_bounds !== 1'b1 && n < 200) begin frame(); n++; end
      vectors++; if (ball_y !== 9'd488 || game_state !== 3'd2) begin miscompares++;
        $display("FAIL oob_edge r%0d: got y %0d st %0d want 488 2", r, ball_y, game_state); end
      frame();
      if (r < 2) begin
        vectors++; if (game_state !== 3'd3 || lives !== 2'(2 - r)) begin miscompares++;
          $display("FAIL lost r%0d: got st %0d lives %0d want 3 %0d",
                   r, game_state, lives, 2 - r); end
        n = 0;
        while (game_state === 3'd3 && n < 100) begin frame(); n++; end
        vectors++; if (n != 60 || game_state !== 3'd1) begin miscompares++;
          $display("FAIL pause r%0d: got %0d frames st %0d want 60 1", r, n, game_state); end
      end else begin
        vectors++; if (game_state !== 3'd4 || lives !== 2'd0) begin miscompares++;
          $display("FAIL game_over: got st %0d lives %0d want 4 0", game_state, lives); end
      end
    end
    btn_action = 1'b1; frame(); btn_action = 1'b0;
    vectors++; if (game_state !== 3'd0) begin miscompares++;
      $display("FAIL over_to_idle: got %0d want 0", game_state); end
  endtask

  task automatic test_paddle();
    btn_left = 1'b1; frame();
    vectors++; if (paddle_x !== 10'd288) begin miscompares++;
      $display("FAIL idle_frozen: got %0d want 288", paddle_x); end
    btn_action = 1'b1; frame(); btn_action = 1'b0;
    repeat (200) frame();
    vectors++; if (paddle_x !== 10'd8 || ball_x !== 10'd38) begin miscompares++;
      $display("FAIL clamp_left: got paddle %0d ball %0d want 8 38", paddle_x, ball_x); end
    btn_left = 1'b0; btn_right = 1'b1;
    repeat (300) frame();
    vectors++; if (paddle_x !== 10'd568 || ball_x !== 10'd598) begin miscompares++;
      $display("FAIL clamp_right: got paddle %0d ball %0d want 568 598", paddle_x, ball_x); end
    btn_left = 1'b1; frame();
    vectors++; if (paddle_x !== 10'd566) begin miscompares++;
      $display("FAIL left_priority: got %0d want 566", paddle_x); end
    btn_left = 1'b0; btn_right = 1'b0;
  endtask

  initial begin
    test_reset();
    test_serve();
    test_bounce();
    test_speed();
    test_stop();
    test_lives();
    test_paddle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
